regfile_write_decode: RTL and testbench
=======================================

Name: regfile_write_decode

Overview:
- 32 x 32-bit general-purpose register file for the pipeline CPU.
- Holds the write side: a 5-to-32 one-hot write decoder driving per-register enables, which is the inverse of the 32-to-1 read selection.
- Two combinational read ports, each a 32-to-1 select, serve the ID stage.
- The write port is driven from the WB stage; optional write-through bypass resolves same-cycle WB-to-ID hazards.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count = 2**ADDR_W
- BYPASS, 1, 1 = a read of the address being written returns i_wdata in the same cycle; 0 = read returns the old contents

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- i_we  input  1  write enable from WB
- i_waddr  input  ADDR_W  write register number
- i_wdata  input  DATA_W  write data
- i_raddr1  input  ADDR_W  read port 1 register number (rs)
- i_raddr2  input  ADDR_W  read port 2 register number (rt)
- o_rdata1  output  DATA_W  read port 1 data
- o_rdata2  output  DATA_W  read port 2 data
- o_we_onehot  output  2**ADDR_W  decoded per-register write strobe (combinational; for verification and debug)

Behaviour:
- Reset:
  - reset_n low clears all registers to 0 asynchronously, independent of clk.
  - While reset_n is low, o_rdata1 and o_rdata2 read 0 for every address, and writes are ignored.
  - If reset asserts during a cycle with i_we=1, reset wins and no write lands.
  - The first write is accepted on the first rising edge after reset_n deasserts.
- Write decode:
  - o_we_onehot[k] = i_we AND (i_waddr == k), for k = 1..31.
  - o_we_onehot[0] is always 0.
  - The vector is at most one-hot; it is all-zero when i_we=0.
- Write: on the rising clk edge with o_we_onehot[k]=1, reg[k] <= i_wdata. Latency is 1 cycle: the new value is architecturally visible from the next cycle.
- Register 0: hardwired zero. Writes to address 0 are discarded, and reads of address 0 always return 0, including under bypass.
- Read:
  - Purely combinational: o_rdataN = reg[i_raddrN]. There is no read latency.
  - Both ports are independent; both may read the same address.
- Bypass (BYPASS=1): if i_we=1, i_waddr == i_raddrN and i_waddr != 0, then o_rdataN = i_wdata in the same cycle (write-first).
- No bypass (BYPASS=0): same-cycle reads return the pre-edge contents.
- Simultaneous events:
  - A write and two reads to the same nonzero address follow the bypass rule on both ports.
  - Back-to-back writes to the same register: the last one wins.
- No X propagation: all registers are reset. Out-of-range addresses cannot occur because the address width matches the register count exactly.

Decomposition:
- Shared package constants:
  - DATA_W = 32
  - ADDR_W = 5
  - NUM_REGS = 32
  - REG_ZERO = 5'd0
  - MIPS register aliases: REG_SP = 29, REG_RA = 31
- Sub-module dec_onehot: ADDR_W-to-2**ADDR_W enable-gated one-hot decoder producing o_we_onehot.
- The register array, reset, and read/bypass logic stay in the top module.

Test Plan:
- Reset check: pre-load regs via writes, assert reset_n=0 mid-cycle -> all reads return 32'h0 immediately, without waiting for a clock edge; o_we_onehot = 0 while i_we=0.
- Write then read:
  - Stimulus: write 32'hDEADBEEF to r5, write 32'h12345678 to r31.
  - Next cycle, raddr1=5 and raddr2=31 -> o_rdata1=32'hDEADBEEF, o_rdata2=32'h12345678.
  - With i_we=1, waddr=5: o_we_onehot=32'h0000_0020.
- Zero register: write 32'hFFFFFFFF to r0 -> o_we_onehot=0; reads of r0 return 32'h0 both the same cycle (BYPASS=1) and the following cycle.
- Bypass:
  - Setup: r7 holds 32'hA; same cycle, write 32'hB to r7 with raddr1=raddr2=7.
  - BYPASS=1 -> both ports read 32'hB in that cycle.
  - BYPASS=0 -> both ports read 32'hA in that cycle and 32'hB in the next.
- Reset vs write: i_we=1, waddr=3, wdata=32'h55; assert reset_n low before the edge, release after -> r3 reads 0.
- Decoder sweep: for k = 0..31, i_we=1, waddr=k, wdata=k*32'h01010101 -> o_we_onehot = (k==0 ? 0 : 1<<k); afterwards every rk reads back its value, with r0 = 0.

Source files
------------

// File: rtl/regfile_write_decode_pkg.sv
// Shared constants for the general-purpose register file.
// Widths, register count and well-known register numbers.
package regfile_write_decode_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_write_decode_dec_onehot.sv
// Enable-gated address-to-one-hot decoder for register write strobes.
// Bit 0 can be forced low so the zero register never sees a strobe.
module dec_onehot #(
  parameter int ADDR_W  = 5,
  parameter bit ZERO_HW = 1'b1
) (
  input  logic                   i_en,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [(1<<ADDR_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
    if (ZERO_HW) begin
      o_onehot[0] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_decode.sv
// 32 x 32 register file: one-hot decoded write port from WB,
// two combinational read ports for ID with optional write-through.
module regfile_write_decode #(
  parameter int DATA_W = regfile_write_decode_pkg::DATA_W,
  parameter int ADDR_W = regfile_write_decode_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_waddr,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic [ADDR_W-1:0]      i_raddr1,
  input  logic [ADDR_W-1:0]      i_raddr2,
  output logic [DATA_W-1:0]      o_rdata1,
  output logic [DATA_W-1:0]      o_rdata2,
  output logic [(1<<ADDR_W)-1:0] o_we_onehot
);

  import regfile_write_decode_pkg::*;

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_live;
  logic              hit1;
  logic              hit2;

  dec_onehot #(
    .ADDR_W  (ADDR_W),
    .ZERO_HW (1'b1)
  ) u_dec (
    .i_en     (i_we),
    .i_addr   (i_waddr),
    .o_onehot (o_we_onehot)
  );

  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      regs_d[k] = regs_q[k];
      if (o_we_onehot[k]) begin
        regs_d[k] = i_wdata;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Forwarding is suppressed in reset so reads stay zero there.
  assign wr_live = reset_n && i_we
                && (i_waddr != ADDR_W'(REG_ZERO));
  assign hit1 = (BYPASS != 0) && wr_live
             && (i_raddr1 == i_waddr);
  assign hit2 = (BYPASS != 0) && wr_live
             && (i_raddr2 == i_waddr);

  always_comb begin
    o_rdata1 = regs_q[i_raddr1];
    o_rdata2 = regs_q[i_raddr2];
    if (hit1) begin
      o_rdata1 = i_wdata;
    end
    if (hit2) begin
      o_rdata2 = i_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_write_decode.sv
// Directed bench for the register file, run side by side
// with write-through enabled and disabled.
module tb_regfile_write_decode;

  logic        clk;
  logic        reset_n;
  logic        i_we;
  logic [4:0]  i_waddr;
  logic [31:0] i_wdata;
  logic [4:0]  i_raddr1;
  logic [4:0]  i_raddr2;
  logic [31:0] b_rdata1, b_rdata2, b_onehot;
  logic [31:0] n_rdata1, n_rdata2, n_onehot;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_write_decode #(
    .DATA_W (32), .ADDR_W (5), .BYPASS (1)
  ) dut_byp (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_we        (i_we),
    .i_waddr     (i_waddr),
    .i_wdata     (i_wdata),
    .i_raddr1    (i_raddr1),
    .i_raddr2    (i_raddr2),
    .o_rdata1    (b_rdata1),
    .o_rdata2    (b_rdata2),
    .o_we_onehot (b_onehot)
  );

  regfile_write_decode #(
    .DATA_W (32), .ADDR_W (5), .BYPASS (0)
  ) dut_nob (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_we        (i_we),
    .i_waddr     (i_waddr),
    .i_wdata     (i_wdata),
    .i_raddr1    (i_raddr1),
    .i_raddr2    (i_raddr2),
    .o_rdata1    (n_rdata1),
    .o_rdata2    (n_rdata2),
    .o_we_onehot (n_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    i_we = we; i_waddr = wa; i_wdata = wd;
    i_raddr1 = r1; i_raddr2 = r2;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_we = 1'b0; i_waddr = '0; i_wdata = '0;
    i_raddr1 = 5'd1; i_raddr2 = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd1", b_rdata1, 32'h0);
    chk("rst_rd2", b_rdata2, 32'h0);
    chk("rst_onehot", b_onehot, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // write r5, onehot and same-cycle forwarding
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31);
    chk("wr5_onehot", b_onehot, 32'h0000_0020);
    chk("wr5_onehot_nb", n_onehot, 32'h0000_0020);
    chk("wr5_byp", b_rdata1, 32'hDEADBEEF);
    chk("wr5_nobyp", n_rdata1, 32'h0);
    drive(1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0);
    chk("wr31_onehot", b_onehot, 32'h8000_0000);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    chk("rd5", b_rdata1, 32'hDEADBEEF);
    chk("rd31", b_rdata2, 32'h12345678);
    chk("rd5_nb", n_rdata1, 32'hDEADBEEF);
    chk("rd31_nb", n_rdata2, 32'h12345678);
    chk("idle_onehot", b_onehot, 32'h0);

    // zero register
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("r0_onehot", b_onehot, 32'h0);
    chk("r0_same1", b_rdata1, 32'h0);
    chk("r0_same2", b_rdata2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("r0_next1", b_rdata1, 32'h0);
    chk("r0_next_nb", n_rdata2, 32'h0);

    // same-cycle overwrite of r7
    drive(1'b1, 5'd7, 32'hA, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 32'hB, 5'd7, 5'd7);
    chk("byp_p1", b_rdata1, 32'hB);
    chk("byp_p2", b_rdata2, 32'hB);
    chk("nobyp_p1", n_rdata1, 32'hA);
    chk("nobyp_p2", n_rdata2, 32'hA);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("after_p1", b_rdata1, 32'hB);
    chk("after_nb_p2", n_rdata2, 32'hB);

    // back-to-back writes: last one wins
    drive(1'b1, 5'd9, 32'h1111, 5'd0, 5'd0);
    drive(1'b1, 5'd9, 32'h2222, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    chk("b2b_last", b_rdata1, 32'h2222);
    chk("b2b_last_nb", n_rdata2, 32'h2222);

    // reset mid-cycle while a write is pending
    drive(1'b1, 5'd3, 32'h99, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'h55, 5'd3, 5'd5);
    reset_n = 1'b0;
    #1;
    chk("rstw_r3_now", b_rdata1, 32'h0);
    chk("rstw_r5_now", b_rdata2, 32'h0);
    chk("rstw_r3_now_nb", n_rdata1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    i_we = 1'b0;
    #1;
    chk("rstw_r3_after", b_rdata1, 32'h0);
    chk("rstw_r3_after_nb", n_rdata1, 32'h0);
    chk("rstw_r5_after", b_rdata2, 32'h0);

    // decoder sweep
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 5'(k), 32'(k) * 32'h01010101, 5'd0, 5'd0);
      chk($sformatf("sweep_onehot_%0d", k), b_onehot,
          (k == 0) ? 32'h0 : (32'h1 << k));
    end
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k));
      chk($sformatf("sweep_rd1_%0d", k), b_rdata1,
          32'(k) * 32'h01010101);
      chk($sformatf("sweep_rd2_nb_%0d", k), n_rdata2,
          32'(31 - k) * 32'h01010101);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
